// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two requester ports and the single-port memory bus around mem_port_arbiter.
// The slave modport is the arbiter's view; master is the combined requester/memory side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              r0_req;
    logic              r0_we;
    logic [ADDR_W-1:0] r0_addr;
    logic [31:0]       r0_wdata;
    logic              r0_gnt;
    logic              r0_ack;
    logic [31:0]       r0_rdata;

    logic              r1_req;
    logic              r1_we;
    logic [ADDR_W-1:0] r1_addr;
    logic [31:0]       r1_wdata;
    logic              r1_gnt;
    logic              r1_ack;
    logic [31:0]       r1_rdata;

    logic [ADDR_W-1:0] mem_address;
    logic [31:0]       mem_wrdata;
    logic              mem_wr;
    logic [31:0]       mem_rddata;
    logic              err;

    modport slave (
        input  r0_req, r0_we, r0_addr, r0_wdata,
        input  r1_req, r1_we, r1_addr, r1_wdata,
        input  mem_rddata,
        output r0_gnt, r0_ack, r0_rdata,
        output r1_gnt, r1_ack, r1_rdata,
        output mem_address, mem_wrdata, mem_wr, err
    );

    modport master (
        output r0_req, r0_we, r0_addr, r0_wdata,
        output r1_req, r1_we, r1_addr, r1_wdata,
        output mem_rddata,
        input  r0_gnt, r0_ack, r0_rdata,
        input  r1_gnt, r1_ack, r1_rdata,
        input  mem_address, mem_wrdata, mem_wr, err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter/sequencer for a single-port word memory (IDLE -> ACCESS -> DONE).
// Define MEM_PORT_ARBITER_FIXED_PRIO_EN for fixed r0 priority instead of round-robin.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 128
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              id_q, id_d;
    logic              oor_q, oor_d;
    logic [31:0]       r0_rdata_q, r0_rdata_d;
    logic [31:0]       r1_rdata_q, r1_rdata_d;
`ifndef MEM_PORT_ARBITER_FIXED_PRIO_EN
    logic              last_q, last_d;
`endif

    logic              any_req;
    logic              win;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       rd_word;

    assign any_req = bus.r0_req | bus.r1_req;

    // Winner select: 0 = r0, 1 = r1.
    always_comb begin
        win = 1'b0;
`ifdef MEM_PORT_ARBITER_FIXED_PRIO_EN
        win = ~bus.r0_req;
`else
        if (bus.r0_req && bus.r1_req) begin
            win = ~last_q;
        end else begin
            win = bus.r1_req;
        end
`endif
    end

    assign sel_addr = win ? bus.r1_addr : bus.r0_addr;
    // Out-of-range reads return zero rather than whatever the memory aliases to.
    assign rd_word  = oor_q ? 32'd0 : bus.mem_rddata;

    // State register plus captured transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            id_q       <= 1'b0;
            oor_q      <= 1'b0;
            r0_rdata_q <= '0;
            r1_rdata_q <= '0;
`ifndef MEM_PORT_ARBITER_FIXED_PRIO_EN
            last_q     <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            id_q       <= id_d;
            oor_q      <= oor_d;
            r0_rdata_q <= r0_rdata_d;
            r1_rdata_q <= r1_rdata_d;
`ifndef MEM_PORT_ARBITER_FIXED_PRIO_EN
            last_q     <= last_d;
`endif
        end
    end

    // Next-state and capture logic.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        id_d       = id_q;
        oor_d      = oor_q;
        r0_rdata_d = r0_rdata_q;
        r1_rdata_d = r1_rdata_q;
`ifndef MEM_PORT_ARBITER_FIXED_PRIO_EN
        last_d     = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = ACCESS;
                    addr_d  = sel_addr;
                    wdata_d = win ? bus.r1_wdata : bus.r0_wdata;
                    we_d    = win ? bus.r1_we : bus.r0_we;
                    id_d    = win;
                    oor_d   = (sel_addr >= ADDR_W'(DEPTH));
`ifndef MEM_PORT_ARBITER_FIXED_PRIO_EN
                    last_d  = win;
`endif
                end
            end
            ACCESS: begin
                state_d = DONE;
                if (!we_q) begin
                    if (id_q) begin
                        r1_rdata_d = rd_word;
                    end else begin
                        r0_rdata_d = rd_word;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode straight from state so reset clears them without waiting for an edge.
    always_comb begin
        bus.mem_address = '0;
        bus.mem_wrdata  = '0;
        bus.mem_wr      = 1'b0;
        bus.r0_gnt      = 1'b0;
        bus.r1_gnt      = 1'b0;
        bus.r0_ack      = 1'b0;
        bus.r1_ack      = 1'b0;
        bus.err         = 1'b0;
        bus.r0_rdata    = r0_rdata_q;
        bus.r1_rdata    = r1_rdata_q;
        case (state_q)
            ACCESS: begin
                bus.mem_address = addr_q;
                bus.mem_wrdata  = wdata_q;
                bus.mem_wr      = we_q & ~oor_q;
                bus.r0_gnt      = ~id_q;
                bus.r1_gnt      = id_q;
            end
            DONE: begin
                bus.r0_gnt = ~id_q;
                bus.r1_gnt = id_q;
                bus.r0_ack = ~id_q;
                bus.r1_ack = id_q;
                bus.err    = oor_q;
            end
            default: begin
            end
        endcase
    end

    a_ack_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.r0_ack && bus.r1_ack));
    a_wr_in_access: assert property (@(posedge clk) disable iff (!rst_n)
        bus.mem_wr |-> (state_q == ACCESS));
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a 128-word behavioural memory.
module tb_mem_port_arbiter;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 128;

    typedef struct {
        bit          id;
        bit          rd;
        logic [31:0] rdata;
        bit          err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();
    mem_port_arbiter #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] mem [DEPTH];
    always @(posedge clk) begin
        if (bus.mem_wr && bus.mem_address < DEPTH) mem[bus.mem_address[6:0]] <= bus.mem_wrdata;
    end
    // Aliased read on purpose: out-of-range reads must be zeroed by the arbiter.
    assign bus.mem_rddata = mem[bus.mem_address[6:0]];

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          wr_cnt   = 0;
    logic [31:0] wr_addr  = '0;
    bit          last_served;

    function automatic logic [31:0] init_word(input int i);
        return 32'h1000_0000 + i * 32'h0001_0101;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Monitor: count memory writes and retire scoreboard entries on each ack.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.mem_wr) begin
                wr_cnt++;
                wr_addr = bus.mem_address;
            end
            if (bus.r0_ack || bus.r1_ack) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_ack", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    $display("txn r%0d %s rdata=%h err=%0d", e.id, e.rd ? "rd" : "wr",
                             e.id ? bus.r1_rdata : bus.r0_rdata, bus.err);
                    check("ack_id", {31'd0, bus.r1_ack}, {31'd0, e.id});
                    check("ack_both", {31'd0, bus.r0_ack & bus.r1_ack}, 0);
                    check("err", {31'd0, bus.err}, {31'd0, e.err});
                    if (e.rd) check("rdata", e.id ? bus.r1_rdata : bus.r0_rdata, e.rdata);
                end
            end
        end
    end

    task automatic set_req(input bit id, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
        if (id) begin
            bus.r1_req = 1'b1; bus.r1_we = we; bus.r1_addr = addr; bus.r1_wdata = wdata;
        end else begin
            bus.r0_req = 1'b1; bus.r0_we = we; bus.r0_addr = addr; bus.r0_wdata = wdata;
        end
    endtask

    task automatic clr_req(input bit id);
        if (id) bus.r1_req = 1'b0;
        else    bus.r0_req = 1'b0;
    endtask

    task automatic push_exp(input bit id, input bit rd, input logic [31:0] rdata, input bit err);
        exp_t e;
        e.id = id; e.rd = rd; e.rdata = rdata; e.err = err;
        sb.push_back(e);
    endtask

    task automatic do_txn(input bit id, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rd, input bit exp_err);
        int cyc;
        bit got;
        push_exp(id, !we, exp_rd, exp_err);
        @(negedge clk);
        set_req(id, we, addr, wdata);
        cyc = 0;
        got = 0;
        while (!got && cyc < 10) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) check("gnt_access", {31'd0, id ? bus.r1_gnt : bus.r0_gnt}, 1);
            got = id ? bus.r1_ack : bus.r0_ack;
        end
        check("ack_latency", cyc, 2);
        clr_req(id);
        last_served = id;
    endtask

    task automatic do_pair(input logic [31:0] a0, input logic [31:0] a1);
        bit first;
        int acks;
        int cyc;
`ifdef MEM_PORT_ARBITER_FIXED_PRIO_EN
        first = 1'b0;
`else
        first = ~last_served;
`endif
        push_exp(first, 1'b1, init_word(first ? int'(a1) : int'(a0)), 1'b0);
        push_exp(~first, 1'b1, init_word(first ? int'(a0) : int'(a1)), 1'b0);
        @(negedge clk);
        set_req(0, 1'b0, a0, 32'd0);
        set_req(1, 1'b0, a1, 32'd0);
        acks = 0;
        cyc = 0;
        while (acks < 2 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (bus.r0_ack) begin clr_req(0); acks++; end
            if (bus.r1_ack) begin clr_req(1); acks++; end
        end
        check("pair_acks", acks, 2);
        check("pair_cycles", cyc, 5);
        clr_req(0);
        clr_req(1);
        last_served = ~first;
    endtask

    initial begin
        logic [31:0] r1_snap;
        int          wr_snap;
        int          cyc;
        bit          got;

        for (int i = 0; i < DEPTH; i++) mem[i] = init_word(i);
        bus.r0_req = 0; bus.r0_we = 0; bus.r0_addr = '0; bus.r0_wdata = '0;
        bus.r1_req = 0; bus.r1_we = 0; bus.r1_addr = '0; bus.r1_wdata = '0;
        rst_n = 1'b0;
        last_served = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_mem_wr", {31'd0, bus.mem_wr}, 0);
        check("rst_mem_addr", bus.mem_address, 0);
        check("rst_gnt", {30'd0, bus.r0_gnt, bus.r1_gnt}, 0);
        check("rst_ack", {30'd0, bus.r0_ack, bus.r1_ack}, 0);
        check("rst_err", {31'd0, bus.err}, 0);
        check("rst_rdata", bus.r0_rdata | bus.r1_rdata, 0);
        rst_n = 1'b1;

        // Contention straight after reset, then again after r1 was served.
        do_pair(32'd10, 32'd11);
        do_pair(32'd12, 32'd13);

        // Write then read back.
        wr_cnt = 0;
        do_txn(0, 1'b1, 32'd5, 32'hA1B2_C3D4, 32'd0, 1'b0);
        check("wr_pulse_count", wr_cnt, 1);
        check("wr_addr", wr_addr, 32'd5);
        check("mem5", mem[5], 32'hA1B2_C3D4);
        do_txn(0, 1'b0, 32'd5, 32'd0, 32'hA1B2_C3D4, 1'b0);

        // r0 served last: round-robin hands r1 the next contention.
        do_pair(32'd20, 32'd21);

        // Out-of-range accesses, including a high address bit that must not wrap.
        wr_snap = wr_cnt;
        do_txn(1, 1'b1, 32'd200, 32'hFFFF_FFFF, 32'd0, 1'b1);
        check("oor_no_write", wr_cnt, wr_snap);
        check("oor_alias_intact", mem[200 % DEPTH], init_word(200 % DEPTH));
        do_txn(1, 1'b0, 32'd200, 32'd0, 32'd0, 1'b1);
        do_txn(0, 1'b0, 32'h8000_0005, 32'd0, 32'd0, 1'b1);
        do_txn(0, 1'b0, 32'd127, 32'd0, init_word(127), 1'b0);

        // Make r1_rdata non-zero, then r0 streams reads with req held.
        do_txn(1, 1'b0, 32'd40, 32'd0, init_word(40), 1'b0);
        r1_snap = bus.r1_rdata;
        for (int k = 0; k < 4; k++) push_exp(0, 1'b1, init_word(k), 1'b0);
        @(negedge clk);
        set_req(0, 1'b0, 32'd0, 32'd0);
        for (int k = 0; k < 4; k++) begin
            cyc = 0;
            got = 0;
            while (!got && cyc < 10) begin
                @(negedge clk);
                cyc++;
                got = bus.r0_ack;
            end
            check("held_interval", cyc, (k == 0) ? 2 : 3);
            if (k < 3) bus.r0_addr = k + 1;
            else clr_req(0);
        end
        check("r1_rdata_kept", bus.r1_rdata, r1_snap);
        last_served = 1'b0;

        // Reset pulse in the ACCESS cycle of an r1 write to word 7.
        @(negedge clk);
        set_req(1, 1'b1, 32'd7, 32'hDEAD_BEEF);
        @(posedge clk);
        #2;
        check("pre_rst_mem_wr", {31'd0, bus.mem_wr}, 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_mem_wr", {31'd0, bus.mem_wr}, 0);
        check("rst_mid_gnt", {30'd0, bus.r0_gnt, bus.r1_gnt}, 0);
        check("rst_mid_ack", {30'd0, bus.r0_ack, bus.r1_ack}, 0);
        clr_req(1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        last_served = 1'b1;
        check("rst_word7", mem[7], init_word(7));
        check("rst_r1_rdata", bus.r1_rdata, 0);
        do_txn(1, 1'b0, 32'd7, 32'd0, init_word(7), 1'b0);

        repeat (3) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
